// File: rtl/native_mem_responder_if.sv
// native_mem_responder_if
// Native memory request/response bus between an initiator and a responder.
//   mem_valid  initiator -> responder  request present, held until mem_ready
//   mem_addr   initiator -> responder  byte address
//   mem_wdata  initiator -> responder  store data
//   mem_wstrb  initiator -> responder  byte enables, all-zero means read
//   mem_ready  responder -> initiator  one-cycle completion strobe
//   mem_rdata  responder -> initiator  read data, valid only with mem_ready
//   mem_err    responder -> initiator  address out of range, valid with mem_ready
interface native_mem_responder_if #(
  parameter int XLEN = 32
) ();
  logic                mem_valid;
  logic                mem_ready;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  logic [XLEN/8-1:0]   mem_wstrb;
  logic [XLEN-1:0]     mem_rdata;
  logic                mem_err;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_err
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_err
  );
endinterface

// File: rtl/native_mem_responder.sv
// native_mem_responder
// Word-addressed memory that answers native bus requests after a fixed
// latency. A request is captured in IDLE, waits LATENCY-1 cycles, and is
// completed by a single-cycle mem_ready in RESP. Writes land at the end of
// the RESP cycle; out-of-range addresses complete with mem_err and no write.
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous active-low reset (memory contents are kept)
//   bus      slave side of native_mem_responder_if
// Only XLEN = 32 is supported; DEPTH must be a power of two.
module native_mem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  native_mem_responder_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  state_t              state_next;
  logic [3:0]          cnt;
  logic [XLEN-3:0]     addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [XLEN/8-1:0]   wstrb_q;
  logic [XLEN-1:0]     mem [DEPTH];
  logic [AW-1:0]       idx;
  logic                in_range;
  logic                unused_addr_bits;

  // The request address is stored as a word address, so the byte offset is
  // dropped at capture time.
  assign unused_addr_bits = ^bus.mem_addr[1:0];
  assign idx              = addr_q[AW-1:0];
  assign in_range         = (addr_q[XLEN-3:AW] == '0);

  // State, latency counter and request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.mem_valid) begin
            addr_q  <= bus.mem_addr[XLEN-1:2];
            wdata_q <= bus.mem_wdata;
            wstrb_q <= bus.mem_wstrb;
            cnt     <= CNT_LOAD;
          end
        end
        WAIT:    cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // Next state and response outputs. mem_valid is only looked at in IDLE,
  // so a request still held during RESP is re-accepted only once back in IDLE.
  always_comb begin
    state_next    = state;
    bus.mem_ready = 1'b0;
    bus.mem_err   = 1'b0;
    bus.mem_rdata = '0;
    case (state)
      IDLE: begin
        if (bus.mem_valid)
          state_next = (LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: begin
        if (cnt == 4'd1)
          state_next = RESP;
      end
      RESP: begin
        state_next    = IDLE;
        bus.mem_ready = 1'b1;
        bus.mem_err   = !in_range;
        if (in_range)
          bus.mem_rdata = mem[idx];
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte-lane writes commit on the edge that ends RESP. A reset during the
  // request forces IDLE first, so an aborted write never reaches the array.
  always_ff @(posedge clk) begin
    if (state == RESP && in_range) begin
      for (int i = 0; i < XLEN/8; i++) begin
        if (wstrb_q[i])
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
